// File: rtl/axi2s_frame_timer.sv
// Sample-rate frame counter with TX/RX window gates and one-shot frame-length adjustment.
// Define FRAME_NUM_EN to build the 32-bit completed-frame counter on frame_num.
module axi2s_frame_timer #(
    parameter int CW      = 24,
    parameter int MIN_LEN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ien,
    input  logic          oen,
    input  logic          tddmode,
    input  logic [CW-1:0] frame_len,
    input  logic [CW-1:0] frame_adj,
    input  logic          adj_req,
    input  logic [CW-1:0] tstart,
    input  logic [CW-1:0] tend,
    input  logic [CW-1:0] rstart,
    input  logic [CW-1:0] rend,
    output logic [CW-1:0] frame_cnt,
    output logic          frame_start,
    output logic          tx_win,
    output logic          rx_win,
    output logic          adj_pending,
    output logic [31:0]   frame_num
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [CW-1:0]        MIN_U    = CW'(MIN_LEN);
    localparam logic [CW-1:0]        MIN_LAST = CW'(MIN_LEN - 1);
    localparam logic [CW-1:0]        MAX_LAST = {{(CW-1){1'b1}}, 1'b0};
    localparam logic signed [CW+1:0] MIN_S    = (CW+2)'(MIN_LEN);
    localparam logic signed [CW+1:0] MAX_S    = {2'b00, {CW{1'b1}}};

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cur_last_q, cur_last_d;
    logic [CW-1:0] adj_q, adj_d;
    logic          pend_q, pend_d;
    logic          tx_q, tx_d;
    logic          rx_q, rx_d;
    logic          run;
    logic          boundary;

    // Last index of an unadjusted frame; lengths below MIN_LEN are raised to it.
    function automatic logic [CW-1:0] nominal_last(input logic [CW-1:0] len);
        if (len < MIN_U) begin
            return MIN_LAST;
        end
        return len - CW'(1);
    endfunction

    // Saturating len + delta; the sum carries a guard bit so a large positive delta cannot wrap.
    function automatic logic [CW-1:0] adjusted_last(input logic [CW-1:0] len,
                                                    input logic [CW-1:0] adj);
        logic signed [CW+1:0] sum;
        sum = $signed({2'b00, len}) + $signed({{2{adj[CW-1]}}, adj});
        if (sum < MIN_S) begin
            return MIN_LAST;
        end
        if (sum > MAX_S) begin
            return MAX_LAST;
        end
        return sum[CW-1:0] - CW'(1);
    endfunction

    // Inclusive window; start > end means the window straddles the frame wrap.
    function automatic logic in_win(input logic [CW-1:0] cnt,
                                    input logic [CW-1:0] win_start,
                                    input logic [CW-1:0] win_end);
        if (win_start <= win_end) begin
            return (cnt >= win_start) && (cnt <= win_end);
        end
        return (cnt >= win_start) || (cnt <= win_end);
    endfunction

    always_comb begin
        run        = ien | oen;
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_last_d = cur_last_q;
        pend_d     = pend_q;
        adj_d      = adj_q;
        boundary   = 1'b0;
        tx_d       = 1'b0;
        rx_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d  = ST_RUN;
                    boundary = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == cur_last_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Enables are both low whenever run is low, so the gates drop on the way to IDLE.
                tx_d = oen & (~tddmode | in_win(cnt_q, tstart, tend));
                rx_d = ien & (~tddmode | in_win(cnt_q, rstart, rend));
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (boundary) begin
            if (pend_q) begin
                cur_last_d = adjusted_last(frame_len, adj_q);
                pend_d     = 1'b0;
            end else begin
                cur_last_d = nominal_last(frame_len);
            end
        end

        // A strobe coinciding with a boundary re-arms rather than being consumed by it.
        if (adj_req) begin
            pend_d = 1'b1;
            adj_d  = frame_adj;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_last_q <= MIN_LAST;
            adj_q      <= '0;
            pend_q     <= 1'b0;
            tx_q       <= 1'b0;
            rx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_last_q <= cur_last_d;
            adj_q      <= adj_d;
            pend_q     <= pend_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    assign frame_cnt   = cnt_q;
    assign frame_start = (state_q == ST_RUN) && (cnt_q == '0);
    assign tx_win      = tx_q;
    assign rx_win      = rx_q;
    assign adj_pending = pend_q;

`ifdef FRAME_NUM_EN
    logic [31:0] num_q, num_d;
    logic        wrap;

    // Only a wrap inside RUN counts; entering RUN from IDLE does not complete a frame.
    assign wrap = (state_q == ST_RUN) && run && (cnt_q == cur_last_q);

    always_comb begin
        num_d = num_q;
        if (wrap) begin
            num_d = num_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= 32'd0;
        end else begin
            num_q <= num_d;
        end
    end

    assign frame_num = num_q;
`else
    assign frame_num = 32'h0;
`endif

endmodule

// File: tb/tb_axi2s_frame_timer.sv
// Directed bench for axi2s_frame_timer: FDD/TDD gating, length adjustment, clamping, reset.
module tb_axi2s_frame_timer;

    localparam int CW = 24;
`ifdef FRAME_NUM_EN
    localparam bit NUM_EN = 1'b1;
`else
    localparam bit NUM_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          ien, oen, tddmode, adj_req;
    logic [CW-1:0] frame_len, frame_adj;
    logic [CW-1:0] tstart, tend, rstart, rend;
    logic [CW-1:0] frame_cnt;
    logic          frame_start, tx_win, rx_win, adj_pending;
    logic [31:0]   frame_num;

    int checks;
    int errors;

    logic [7:0] tx_tbl;
    logic [7:0] rx_tbl;

    axi2s_frame_timer #(.CW(CW), .MIN_LEN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ien         (ien),
        .oen         (oen),
        .tddmode     (tddmode),
        .frame_len   (frame_len),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start),
        .tx_win      (tx_win),
        .rx_win      (rx_win),
        .adj_pending (adj_pending),
        .frame_num   (frame_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] exp_num(input int n);
        return NUM_EN ? 32'(n) : 32'd0;
    endfunction

    // Called on a cnt==0 cycle; walks one whole frame of len cycles and stops on the next cnt==0.
    task automatic expect_frame(input int len, input string tag);
        check({tag, "_cnt0"}, 32'(frame_cnt), 32'd0);
        check({tag, "_start"}, 32'(frame_start), 32'd1);
        for (int j = 1; j < len; j++) begin
            step();
            check({tag, "_cnt"}, 32'(frame_cnt), 32'(j));
            check({tag, "_nostart"}, 32'(frame_start), 32'd0);
        end
        step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ien       = 1'b0;
        oen       = 1'b0;
        tddmode   = 1'b0;
        adj_req   = 1'b0;
        frame_len = 24'd8;
        frame_adj = 24'd0;
        tstart    = '0;
        tend      = '0;
        rstart    = '0;
        rend      = '0;
        tx_tbl    = 8'b0011_1000;
        rx_tbl    = 8'b1000_0111;

        repeat (2) step();
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_start", 32'(frame_start), 32'd0);
        check("rst_tx", 32'(tx_win), 32'd0);
        check("rst_rx", 32'(rx_win), 32'd0);
        check("rst_pend", 32'(adj_pending), 32'd0);
        check("rst_num", frame_num, 32'd0);

        rst_n = 1'b1;
        step();
        check("idle_cnt", 32'(frame_cnt), 32'd0);
        check("idle_start", 32'(frame_start), 32'd0);

        // FDD, TX only, nominal 8-sample frames
        oen = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            check("fdd_cnt", 32'(frame_cnt), 32'(i % 8));
            check("fdd_start", 32'(frame_start), 32'((i % 8) == 0));
            check("fdd_tx", 32'(tx_win), 32'(i != 0));
            check("fdd_rx", 32'(rx_win), 32'd0);
            step();
        end

        // +3 adjustment requested mid-frame
        repeat (3) step();
        check("adjp_cnt3", 32'(frame_cnt), 32'd3);
        frame_adj = 24'd3;
        adj_req   = 1'b1;
        step();
        adj_req = 1'b0;
        check("adjp_pend_set", 32'(adj_pending), 32'd1);
        check("adjp_cnt4", 32'(frame_cnt), 32'd4);
        repeat (3) step();
        check("adjp_cnt7", 32'(frame_cnt), 32'd7);
        check("adjp_pend_hold", 32'(adj_pending), 32'd1);
        step();
        check("adjp_pend_clr", 32'(adj_pending), 32'd0);
        expect_frame(11, "adjp_f11");
        expect_frame(8, "adjp_f8");
        check("adjp_num", frame_num, exp_num(5));

        // -10 adjustment on an 8-sample frame clamps to 2
        repeat (2) step();
        frame_adj = 24'hFFFFF6;
        adj_req   = 1'b1;
        step();
        adj_req = 1'b0;
        check("clamp_pend", 32'(adj_pending), 32'd1);
        repeat (5) step();
        check("clamp_pend_clr", 32'(adj_pending), 32'd0);
        expect_frame(2, "clamp_f2");
        expect_frame(8, "clamp_f8");
        check("clamp_num", frame_num, exp_num(8));

        // strobe on a cnt==0 cycle: current frame stays nominal
        check("late_cnt0", 32'(frame_cnt), 32'd0);
        frame_adj = 24'd3;
        adj_req   = 1'b1;
        step();
        adj_req = 1'b0;
        check("late_pend", 32'(adj_pending), 32'd1);
        check("late_cnt1", 32'(frame_cnt), 32'd1);
        repeat (7) step();
        check("late_wrap8", 32'(frame_cnt), 32'd0);
        check("late_pend_clr", 32'(adj_pending), 32'd0);
        expect_frame(11, "late_f11");
        expect_frame(8, "late_f8");
        check("late_num", frame_num, exp_num(11));

        // TDD windows: TX 2..4, RX wrapping 6..1
        tddmode = 1'b1;
        ien     = 1'b1;
        tstart  = 24'd2;
        tend    = 24'd4;
        rstart  = 24'd6;
        rend    = 24'd1;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("tdd_cnt", 32'(frame_cnt), 32'(c % 8));
            check("tdd_tx", 32'(tx_win), 32'(tx_tbl[c % 8]));
            check("tdd_rx", 32'(rx_win), 32'(rx_tbl[c % 8]));
        end
        check("tdd_num", frame_num, exp_num(12));

        // asynchronous reset at cnt=5 with an adjustment pending
        repeat (3) step();
        frame_adj = 24'd3;
        adj_req   = 1'b1;
        step();
        adj_req = 1'b0;
        check("mrst_pend", 32'(adj_pending), 32'd1);
        step();
        check("mrst_cnt5", 32'(frame_cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_cnt", 32'(frame_cnt), 32'd0);
        check("mrst_start", 32'(frame_start), 32'd0);
        check("mrst_tx", 32'(tx_win), 32'd0);
        check("mrst_rx", 32'(rx_win), 32'd0);
        check("mrst_pend_clr", 32'(adj_pending), 32'd0);
        check("mrst_num", frame_num, 32'd0);
        tddmode = 1'b0;
        ien     = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_num0", frame_num, 32'd0);
        check("post_pend", 32'(adj_pending), 32'd0);
        expect_frame(8, "post_f8");
        check("post_num1", frame_num, exp_num(1));

        // back to IDLE
        oen = 1'b0;
        step();
        check("stop_cnt", 32'(frame_cnt), 32'd0);
        check("stop_start", 32'(frame_start), 32'd0);
        check("stop_tx", 32'(tx_win), 32'd0);
        step();
        check("stop_hold_cnt", 32'(frame_cnt), 32'd0);
        check("stop_hold_start", 32'(frame_start), 32'd0);
        check("stop_num", frame_num, exp_num(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
